// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: fetches one word at pc_in over a req/ack handshake, decodes it,
// and presents registered control strobes for exactly one accepted issue cycle.
module instr_fetch_decode #(
  parameter int PC_W    = 19,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_in,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               ex_busy,
  output logic               ctrl_valid,
  output logic [3:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [5:0]         imm,
  output logic               jump,
  output logic               beq,
  output logic               bne,
  output logic               call,
  output logic               ret,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic [1:0]         alu_op,
  output logic               illegal,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, DECODE, ISSUE, HALTED} state_t;

  typedef struct packed {
    logic       jump;
    logic       beq;
    logic       bne;
    logic       call;
    logic       ret;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [3:0] OP_HALT = 4'd13;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [2:0]         rd_q, rd_d;
  logic [2:0]         rs1_q, rs1_d;
  logic [2:0]         rs2_q, rs2_d;
  logic [5:0]         imm_q, imm_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic               halted_q, halted_d;

  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = op[1:0];
      end
      4'd4: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      4'd5: begin
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
      end
      4'd6: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      4'd7: begin
        c.jump    = 1'b1;
        c.alu_src = 1'b1;
      end
      4'd8: begin
        c.beq    = 1'b1;
        c.alu_op = 2'b01;
      end
      4'd9: begin
        c.bne    = 1'b1;
        c.alu_op = 2'b01;
      end
      4'd10: begin
        c.call    = 1'b1;
        c.alu_src = 1'b1;
      end
      4'd11:   c.ret = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    halted_d  = halted_q;

    case (state_q)
      FETCH: begin
        // req is only low here on the first cycle after reset; raise it then
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_in;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opcode_d = ir_q[18:15];
        rd_d     = ir_q[14:12];
        rs1_d    = ir_q[11:9];
        rs2_d    = ir_q[8:6];
        imm_d    = ir_q[5:0];
        ctrl_d   = decode_op(ir_q[18:15]);
        valid_d  = 1'b1;
        if (ir_q[18:15] >= 4'd14) begin
          illegal_d = 1'b1;
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!ex_busy) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
          if (opcode_q == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc_in;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      req_q     <= 1'b0;
      addr_q    <= '0;
      ir_q      <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ctrl_valid = valid_q;
  assign opcode     = opcode_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign imm        = imm_q;
  assign jump       = ctrl_q.jump;
  assign beq        = ctrl_q.beq;
  assign bne        = ctrl_q.bne;
  assign call       = ctrl_q.call;
  assign ret        = ctrl_q.ret;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = illegal_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a per-cycle compare against a decode-table model,
// plus literal expectations for the key instructions.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] pc_in;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        imem_ack;
  logic        ex_busy;
  logic        ctrl_valid;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [5:0]  imm;
  logic        jump, beq, bne, call, ret, mem_read, mem_write;
  logic        alu_src, reg_dst, mem_to_reg, reg_write;
  logic [1:0]  alu_op;
  logic        illegal, halted;

  int checks = 0;
  int errors = 0;

  // model state, written only by the stimulus
  logic [18:0] cur_word = '0;
  logic [18:0] exp_addr = '0;
  logic        exp_illegal = 1'b0;
  logic        exp_halted = 1'b0;
  logic        cmp_en = 1'b0;

  logic [12:0] snap_ctrl;
  logic [2:0]  snap_rd, snap_rs1, snap_rs2;
  logic        snap_illegal;
  int          last_vcnt;

  instr_fetch_decode #(.PC_W(19), .INSTR_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .ex_busy(ex_busy), .ctrl_valid(ctrl_valid),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .jump(jump), .beq(beq), .bne(bne), .call(call), .ret(ret),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] act_ctrl();
    return {jump, beq, bne, call, ret, mem_read, mem_write, alu_src,
            reg_dst, mem_to_reg, reg_write, alu_op};
  endfunction

  // Expected strobes, expressed per output as the set of opcodes that assert it
  function automatic logic [12:0] exp_ctrl(input logic [3:0] op);
    logic j, bq, bn, c, r, mr, mw, as, rdst, m2r, rw;
    logic [1:0] aop;
    j    = (op == 4'd7);
    bq   = (op == 4'd8);
    bn   = (op == 4'd9);
    c    = (op == 4'd10);
    r    = (op == 4'd11);
    mr   = (op == 4'd5);
    mw   = (op == 4'd6);
    as   = op inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
    rdst = (op <= 4'd3);
    m2r  = (op == 4'd5);
    rw   = (op <= 4'd5);
    if (op <= 4'd3)                     aop = op[1:0];
    else if (op == 4'd8 || op == 4'd9) aop = 2'b01;
    else                                aop = 2'b00;
    return {j, bq, bn, c, r, mr, mw, as, rdst, m2r, rw, aop};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      if (ctrl_valid === 1'b1) begin
        chk("cmp_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(cur_word[18:15])));
        chk("cmp_fields", 32'({opcode, rd, rs1, rs2, imm}), 32'(cur_word));
        chk("cmp_illegal", 32'(illegal), 32'(exp_illegal));
      end else begin
        chk("cmp_idle_strobes", 32'(act_ctrl()), 32'd0);
      end
      chk("cmp_halted", 32'(halted), 32'(exp_halted));
      if (exp_halted) chk("cmp_halt_quiet", 32'({imem_req, ctrl_valid}), 32'd0);
    end
  end

  // One instruction: called at a negedge; pc for the following fetch is next_pc
  task automatic do_instr(input logic [18:0] word, input int waits, input int busy,
                          input logic [18:0] next_pc);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", 32'(n < 20), 32'd1);
    chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      pc_in = 19'($urandom);
      @(negedge clk);
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_stable", 32'(imem_addr), 32'(exp_addr));
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    cur_word = word;
    if (word[18:15] >= 4'd14) exp_illegal = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 19'($urandom);
    chk("decode_gap", 32'({imem_req, ctrl_valid}), 32'd0);
    @(negedge clk);
    chk("issue_latency", 32'(ctrl_valid), 32'd1);
    snap_ctrl = act_ctrl();
    snap_rd = rd;
    snap_rs1 = rs1;
    snap_rs2 = rs2;
    snap_illegal = illegal;
    last_vcnt = 0;
    for (int j = 0; j <= busy; j++) begin
      if (j > 0) @(negedge clk);
      if (ctrl_valid === 1'b1) last_vcnt++;
      ex_busy = (j < busy);
      pc_in = 19'($urandom);
    end
    pc_in = next_pc;
    exp_addr = next_pc;
    if (word[18:15] == 4'd13) exp_halted = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(ctrl_valid), 32'd0);
    if (word[18:15] == 4'd13) begin
      chk("halt_entry", 32'({halted, imem_req}), 32'b10);
    end else begin
      chk("next_fetch", 32'({imem_req, imem_addr}), 32'({1'b1, next_pc}));
    end
    $display("instr word=%05h op=%0d waits=%0d busy=%0d valid_cycles=%0d", word,
             word[18:15], waits, busy, last_vcnt);
  endtask

  task automatic reset_check(input string tag);
    #1;
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(ctrl_valid), 32'd0);
    chk({tag, "_fields"}, 32'({opcode, rd, rs1, rs2, imm}), 32'd0);
    chk({tag, "_strobes"}, 32'(act_ctrl()), 32'd0);
    chk({tag, "_flags"}, 32'({illegal, halted}), 32'd0);
  endtask

  initial begin
    logic [3:0] ops[11];
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd14};
    rst_n = 1'b0;
    pc_in = '0;
    imem_rdata = '0;
    imem_ack = 1'b0;
    ex_busy = 1'b0;
    reset_check("reset");
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 19'd0;
    #1 chk("req_low_before_edge", 32'(imem_req), 32'd0);

    // ADD 0x01240: rd=1 rs1=1 rs2=1 from bit fields
    do_instr(19'h01240, 0, 0, 19'h00100);
    chk("pin_add_ctrl", 32'(snap_ctrl), 32'h014);
    chk("pin_add_regs", 32'({snap_rd, snap_rs1, snap_rs2}), 32'({3'd1, 3'd1, 3'd1}));

    // LD with 3 wait cycles
    do_instr({4'd5, 3'd2, 3'd3, 3'd0, 6'd9}, 3, 0, 19'h00200);
    chk("pin_ld_ctrl", 32'(snap_ctrl), 32'h0AC);

    // CALL held 2 cycles by ex_busy
    do_instr({4'd10, 15'h1234}, 0, 2, 19'h00300);
    chk("pin_call_ctrl", 32'(snap_ctrl), 32'h220);
    chk("pin_call_valid_cycles", 32'(last_vcnt), 32'd3);

    // Opcode 15 then ADD: illegal sticky
    do_instr({4'd15, 15'h7FFF}, 1, 0, 19'h00304);
    chk("pin_op15_ctrl", 32'(snap_ctrl), 32'd0);
    chk("pin_op15_illegal", 32'(snap_illegal), 32'd1);
    do_instr({4'd0, 3'd7, 3'd6, 3'd5, 6'd0}, 0, 1, 19'h00400);
    chk("pin_illegal_sticky", 32'(snap_illegal), 32'd1);

    foreach (ops[i]) begin
      do_instr({ops[i], 15'($urandom)}, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 19'(20'h00500 + 20'(i * 4)));
    end

    // HALT
    do_instr(19'h68000, 0, 0, 19'h00600);
    chk("pin_halt_valid_cycles", 32'(last_vcnt), 32'd1);
    for (int k = 0; k < 20; k++) begin
      imem_ack = k[0];
      @(negedge clk);
      chk("halt_stay", 32'({halted, imem_req, ctrl_valid}), 32'b100);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    exp_halted = 1'b0;
    exp_illegal = 1'b0;
    reset_check("halt_reset");
    @(negedge clk);
    pc_in = 19'h00040;
    exp_addr = 19'h00040;
    rst_n = 1'b1;
    do_instr({4'd1, 3'd3, 3'd4, 3'd5, 6'd33}, 0, 0, 19'h00050);
    chk("pin_after_reset_illegal", 32'(snap_illegal), 32'd0);

    // Reset while awaiting ack; ack across reset release is ignored
    chk("pre_midreset_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    reset_check("mid_reset");
    imem_ack = 1'b1;
    imem_rdata = 19'h0AAAA;
    repeat (2) @(negedge clk);
    pc_in = 19'h00055;
    exp_addr = 19'h00055;
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_first_edge", 32'({imem_req, ctrl_valid, imem_addr}), 32'({2'b10, 19'h00055}));
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", 32'({imem_req, ctrl_valid}), 32'b10);
    do_instr({4'd8, 3'd1, 3'd2, 3'd3, 6'd4}, 1, 0, 19'h00060);
    chk("pin_beq_ctrl", 32'(snap_ctrl), 32'h801);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
